seg7_spi_rx: RTL and testbench

SPI mode-0 slave that receives display commands from the external microcontroller and holds the display state. It sits directly upstream of the dual 7-segment decoder and drives that decoder's data[7:0], blank and test inputs from registers. SCLK, CS_N and MOSI are asynchronous to clk. They are oversampled through synchronizers, and all logic runs in the clk domain.

---
 rtl/seg7_spi_pkg.sv | 21 ++
 rtl/sync_edge.sv | 33 +++
 rtl/seg7_spi_rx.sv | 139 +++++++++++++
 tb/tb_seg7_spi_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_spi_pkg.sv
// Shared frame constants, command codes and receiver states for the
// seg7 SPI display-command receiver.
package seg7_spi_pkg;

  localparam int FRAME_BITS = 16;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_CTRL  = 8'h02;
  localparam logic [7:0] CMD_SHOW  = 8'h03;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_CTRL) || (cmd == CMD_SHOW);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous input, with rise/fall
// strobes derived from the synchronized level.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Resetting to 0 means a line held low through reset never looks like a
  // falling edge afterwards; it has to be seen high first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/seg7_spi_rx.sv
// SPI mode-0 slave that receives 16-bit display commands and holds the
// data/blank/test registers feeding the dual 7-segment decoder.
import seg7_spi_pkg::*;

module seg7_spi_rx #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_DATA  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sclk,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [7:0] data,
  output logic       blank,
  output logic       test,
  output logic       frame_valid,
  output logic       frame_err
);

  localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
  localparam logic [4:0] CNT_MAX  = 5'(FRAME_BITS + 1);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic cs_sync, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic mosi_s;

  state_t                state;
  logic                  armed;
  logic [4:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [7:0]            shadow;
  logic [7:0]            cmd, operand;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .sync  (sclk_lvl_unused),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .sync  (cs_sync),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Same depth as the sclk path so mosi is sampled aligned with the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mosi_chain <= '0;
    else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_s  = mosi_chain[SYNC_STAGES-1];
  assign cmd     = shift_reg[15:8];
  assign operand = shift_reg[7:0];

  // A cs_n rising edge takes priority over any sclk edge in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      shadow      <= '0;
      miso        <= 1'b0;
      data        <= RESET_DATA;
      blank       <= 1'b1;
      test        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_sync) armed <= 1'b1;
          if (cs_fall && armed) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            shadow    <= data;
            miso      <= data[7];
            armed     <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state <= CHECK;
          end else begin
            if (sclk_rise) begin
              shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_s};
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 5'd1;
            end
            if (sclk_fall) begin
              if (bit_cnt < 5'd8) begin
                miso   <= shadow[6];
                shadow <= {shadow[6:0], 1'b0};
              end else begin
                miso <= 1'b0;
              end
            end
          end
        end
        CHECK: begin
          if (bit_cnt == CNT_FULL && is_valid_cmd(cmd)) begin
            case (cmd)
              CMD_WRITE: data <= operand;
              CMD_CTRL: begin
                blank <= operand[0];
                test  <= operand[1];
              end
              default: begin
                data  <= operand;
                blank <= 1'b0;
                test  <= 1'b0;
              end
            endcase
            frame_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
          miso  <= 1'b0;
          armed <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_spi_rx.sv
// Self-checking bench for seg7_spi_rx: table-driven directed frames, a
// reset-mid-frame sequence and random frames against a behavioural model.
module tb_seg7_spi_rx;

  localparam int SYNC_STAGES = 2;
  localparam int LAT         = SYNC_STAGES + 2;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi;
  logic       miso, blank, test, frame_valid, frame_err;
  logic [7:0] data;

  int passed = 0, total = 0;
  int valid_cnt = 0, err_cnt = 0, both_cnt = 0;
  int half = 25;

  logic [7:0] m_data;
  logic       m_blank, m_test;

  typedef struct {
    logic [31:0] word;
    int          nbits;
    logic [7:0]  exp_data;
    logic        exp_blank;
    logic        exp_test;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[10];

  always #10 clk = ~clk;

  seg7_spi_rx #(.SYNC_STAGES(SYNC_STAGES), .RESET_DATA(8'h00)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .data(data), .blank(blank), .test(test),
    .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (frame_valid) valid_cnt++;
    if (frame_err) err_cnt++;
    if (frame_valid && frame_err) both_cnt++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic csLow();
    @(negedge clk);
    cs_n = 1'b0;
    waitClks(half);
  endtask

  // Master samples miso just before raising sclk.
  task automatic shiftBit(input logic b, output logic seen);
    mosi = b;
    waitClks(half);
    seen = miso;
    sclk = 1'b1;
    waitClks(half);
    sclk = 1'b0;
  endtask

  task automatic csHigh(output int lat);
    @(negedge clk);
    cs_n = 1'b1;
    lat = -1;
    for (int k = 1; k <= LAT + 8; k++) begin
      @(posedge clk);
      #1;
      if (lat < 0 && (frame_valid || frame_err)) lat = k;
    end
    waitClks(4);
  endtask

  task automatic applyStimulus(input logic [31:0] word, input int nbits,
                               output logic [31:0] rb, output int lat);
    logic s;
    csLow();
    rb = '0;
    for (int i = 0; i < nbits; i++) begin
      shiftBit(word[nbits-1-i], s);
      rb = {rb[30:0], s};
    end
    waitClks(half);
    csHigh(lat);
  endtask

  // Expected readback: the pre-frame data byte MSB first, zeros after bit 8.
  function automatic logic [31:0] expReadback(input logic [7:0] d, input int nbits);
    logic [31:0] r = '0;
    for (int i = 0; i < nbits; i++) r = {r[30:0], (i < 8) ? d[7-i] : 1'b0};
    return r;
  endfunction

  task automatic modelFrame(input logic [31:0] word, input int nbits, output logic ev);
    logic [7:0] c, op;
    c  = word[15:8];
    op = word[7:0];
    ev = 1'b0;
    if (nbits == 16) begin
      if (c == 8'h01) begin m_data = op; ev = 1'b1; end
      else if (c == 8'h02) begin m_blank = op[0]; m_test = op[1]; ev = 1'b1; end
      else if (c == 8'h03) begin m_data = op; m_blank = 1'b0; m_test = 1'b0; ev = 1'b1; end
    end
  endtask

  task automatic checkFrame(input string tag, input int v0, input int e0, input logic ev,
                            input int lat, input logic [31:0] rb, input logic [31:0] erb,
                            input logic [7:0] ed, input logic eb, input logic et);
    checkOutput({tag, " valid_pulses"}, valid_cnt - v0, ev ? 1 : 0);
    checkOutput({tag, " err_pulses"}, err_cnt - e0, ev ? 0 : 1);
    checkOutput({tag, " latency"}, lat, LAT);
    checkOutput({tag, " data"}, int'(data), int'(ed));
    checkOutput({tag, " blank"}, int'(blank), int'(eb));
    checkOutput({tag, " test"}, int'(test), int'(et));
    checkOutput({tag, " readback"}, int'(rb), int'(erb));
  endtask

  initial begin
    logic [31:0] rb, word;
    logic [7:0]  prev_data;
    logic        s, ev;
    int          lat, v0, e0, nb;

    vecs[0] = '{32'h03A5,   16, 8'hA5, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h0202,   16, 8'hA5, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{32'h013C,   16, 8'h3C, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{32'h015A,   16, 8'h5A, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{32'h0355,   12, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h106AB,  17, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{32'h7F00,   16, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'h0000,    0, 8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'h0203,   16, 8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[9] = '{32'h03C3,   16, 8'hC3, 1'b0, 1'b0, 1'b1};

    reset = 1'b1; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    waitClks(5);
    reset = 1'b0;
    waitClks(20);
    checkOutput("reset data", int'(data), 8'h00);
    checkOutput("reset blank", int'(blank), 1);
    checkOutput("reset test", int'(test), 0);
    checkOutput("reset miso", int'(miso), 0);
    checkOutput("reset pulses", valid_cnt + err_cnt, 0);

    prev_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      applyStimulus(vecs[i].word, vecs[i].nbits, rb, lat);
      checkFrame($sformatf("vec%0d", i), v0, e0, vecs[i].exp_valid, lat, rb,
                 expReadback(prev_data, vecs[i].nbits), vecs[i].exp_data,
                 vecs[i].exp_blank, vecs[i].exp_test);
      prev_data = vecs[i].exp_data;
    end
    m_data = 8'hC3; m_blank = 1'b0; m_test = 1'b0;

    // Reset lands at bit 9 of a SHOW frame; cs_n stays low across it.
    v0 = valid_cnt; e0 = err_cnt;
    word = 32'h0377;
    csLow();
    for (int i = 0; i < 9; i++) shiftBit(word[15-i], s);
    reset = 1'b1;
    waitClks(3);
    checkOutput("midreset data", int'(data), 8'h00);
    checkOutput("midreset blank", int'(blank), 1);
    checkOutput("midreset miso", int'(miso), 0);
    reset = 1'b0;
    waitClks(2);
    for (int i = 9; i < 16; i++) shiftBit(word[15-i], s);
    waitClks(half);
    csHigh(lat);
    waitClks(5);
    checkOutput("midreset valid_pulses", valid_cnt - v0, 0);
    checkOutput("midreset err_pulses", err_cnt - e0, 0);
    checkOutput("midreset data_after", int'(data), 8'h00);
    checkOutput("midreset blank_after", int'(blank), 1);
    checkOutput("midreset test_after", int'(test), 0);
    m_data = 8'h00; m_blank = 1'b1; m_test = 1'b0;

    v0 = valid_cnt; e0 = err_cnt;
    prev_data = m_data;
    applyStimulus(32'h0155, 16, rb, lat);
    modelFrame(32'h0155, 16, ev);
    checkFrame("post_reset", v0, e0, ev, lat, rb, expReadback(prev_data, 16),
               m_data, m_blank, m_test);

    half = 6;
    for (int n = 0; n < 30; n++) begin
      int r;
      logic [7:0] c, op;
      r  = $urandom_range(0, 4);
      c  = (r < 3) ? 8'(r + 1) : 8'($urandom_range(0, 255));
      op = 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 9);
      nb = (r == 0) ? 15 : (r == 1) ? 17 : 16;
      word = (nb == 17) ? {15'd0, c, op, 1'($urandom_range(0, 1))} : {16'd0, c, op};
      v0 = valid_cnt; e0 = err_cnt;
      prev_data = m_data;
      applyStimulus(word, nb, rb, lat);
      modelFrame(word, nb, ev);
      checkFrame($sformatf("rand%0d", n), v0, e0, ev, lat, rb,
                 expReadback(prev_data, nb), m_data, m_blank, m_test);
    end

    checkOutput("never_both_pulses", both_cnt, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
